// File: rtl/jk_bank_pkg.sv
// Purpose: shared opcodes and FSM state type for the JK bank controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package jk_bank_pkg;

  localparam logic [1:0] OP_JK    = 2'b00;
  localparam logic [1:0] OP_COUNT = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_LOAD  = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_t;

endpackage

// File: rtl/jk_cell.sv
// Purpose: one behavioural JK storage bit with asynchronous clear.
// Latency: q follows J/K at the next rising edge; clear acts immediately.
// Backpressure: none.
// Ports: clk, CLR_N (async active-low clear), j, k -> q, qbar.
module jk_cell (
  input  logic clk,
  input  logic CLR_N,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qbar
);

  always_ff @(posedge clk or negedge CLR_N) begin
    if (!CLR_N) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b10:   q <= 1'b1;
        2'b01:   q <= 1'b0;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

  assign qbar = ~q;

endmodule

// File: rtl/jk_bank_ctrl.sv
// Purpose: shares a WIDTH-bit JK bank between two requesters (JK/COUNT/READ/LOAD).
// Latency: response 1 cycle after the command's last q update; COUNT len=L takes L+1 updates.
// Backpressure: round-robin ready in IDLE only; no ready during COUNT; responses cannot stall.
// Ports: r0_*/r1_* request channels (valid/ready, op, j, k, len), q/qbar bank state,
//        busy (COUNT in progress), rsp_valid/rsp_id/rsp_q/rsp_carry one-cycle response.
module jk_bank_ctrl
  import jk_bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LENW  = 4
) (
  input  logic             clk,
  input  logic             CLR_N,
  input  logic             r0_valid,
  input  logic [1:0]       r0_op,
  input  logic [WIDTH-1:0] r0_j,
  input  logic [WIDTH-1:0] r0_k,
  input  logic [LENW-1:0]  r0_len,
  output logic             r0_ready,
  input  logic             r1_valid,
  input  logic [1:0]       r1_op,
  input  logic [WIDTH-1:0] r1_j,
  input  logic [WIDTH-1:0] r1_k,
  input  logic [LENW-1:0]  r1_len,
  output logic             r1_ready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             busy,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_q,
  output logic             rsp_carry
);

  state_t            state, state_nxt;
  logic [LENW-1:0]   rem, rem_nxt;
  logic              last_grant;
  logic              cmd_id, cmd_id_nxt;
  logic              carry_flag, carry_flag_nxt;

  logic              gnt0, gnt1, acc;
  logic [1:0]        acc_op;
  logic [WIDTH-1:0]  acc_j, acc_k;
  logic [LENW-1:0]   acc_len;

  logic [WIDTH-1:0]  inc_t;
  logic              wrap;
  logic [WIDTH-1:0]  j_drv, k_drv, q_nxt;
  logic              rsp_set, rsp_carry_nxt;

  // Arbiter: ready is combinational and gated by CLR_N so nothing is offered in reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == ST_IDLE && CLR_N) begin
      if (r0_valid && r1_valid) begin
        if (last_grant) gnt0 = 1'b1;
        else            gnt1 = 1'b1;
      end else if (r0_valid) begin
        gnt0 = 1'b1;
      end else if (r1_valid) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign r0_ready = gnt0;
  assign r1_ready = gnt1;
  assign acc      = gnt0 | gnt1;
  assign acc_op   = gnt1 ? r1_op  : r0_op;
  assign acc_j    = gnt1 ? r1_j   : r0_j;
  assign acc_k    = gnt1 ? r1_k   : r0_k;
  assign acc_len  = gnt1 ? r1_len : r0_len;

  // Synchronous counter drive: bit i toggles when all lower bits are one.
  always_comb begin
    inc_t    = '0;
    inc_t[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      inc_t[i] = inc_t[i-1] & q[i-1];
    end
  end

  assign wrap = &q;

  // Next-state, J/K drive mux and response qualification.
  always_comb begin
    state_nxt      = state;
    rem_nxt        = rem;
    cmd_id_nxt     = cmd_id;
    carry_flag_nxt = carry_flag;
    j_drv          = '0;
    k_drv          = '0;
    rsp_set        = 1'b0;
    rsp_carry_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (acc) begin
          cmd_id_nxt     = gnt1;
          carry_flag_nxt = 1'b0;
          case (acc_op)
            OP_JK: begin
              j_drv   = acc_j;
              k_drv   = acc_k;
              rsp_set = 1'b1;
            end
            OP_LOAD: begin
              j_drv   = acc_j;
              k_drv   = ~acc_j;
              rsp_set = 1'b1;
            end
            OP_COUNT: begin
              j_drv          = inc_t;
              k_drv          = inc_t;
              carry_flag_nxt = wrap;
              if (acc_len == '0) begin
                rsp_set       = 1'b1;
                rsp_carry_nxt = wrap;
              end else begin
                state_nxt = ST_COUNT;
                rem_nxt   = acc_len;
              end
            end
            default: begin
              rsp_set = 1'b1;
            end
          endcase
        end
      end
      ST_COUNT: begin
        j_drv          = inc_t;
        k_drv          = inc_t;
        carry_flag_nxt = carry_flag | wrap;
        rem_nxt        = rem - LENW'(1);
        if (rem == LENW'(1)) begin
          state_nxt     = ST_IDLE;
          rsp_set       = 1'b1;
          rsp_carry_nxt = carry_flag | wrap;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Value the bank will hold after this edge, captured into rsp_q.
  always_comb begin
    q_nxt = q;
    for (int i = 0; i < WIDTH; i++) begin
      case ({j_drv[i], k_drv[i]})
        2'b10:   q_nxt[i] = 1'b1;
        2'b01:   q_nxt[i] = 1'b0;
        2'b11:   q_nxt[i] = ~q[i];
        default: q_nxt[i] = q[i];
      endcase
    end
  end

  always_ff @(posedge clk or negedge CLR_N) begin
    if (!CLR_N) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge CLR_N) begin
    if (!CLR_N) begin
      rem        <= '0;
      last_grant <= 1'b1;
      cmd_id     <= 1'b0;
      carry_flag <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_q      <= '0;
      rsp_carry  <= 1'b0;
    end else begin
      rem        <= rem_nxt;
      cmd_id     <= cmd_id_nxt;
      carry_flag <= carry_flag_nxt;
      rsp_valid  <= rsp_set;
      if (acc) last_grant <= gnt1;
      if (rsp_set) begin
        rsp_id    <= cmd_id_nxt;
        rsp_q     <= q_nxt;
        rsp_carry <= rsp_carry_nxt;
      end
    end
  end

  assign busy = (state == ST_COUNT);

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_cell u_cell (
      .clk   (clk),
      .CLR_N (CLR_N),
      .j     (j_drv[g]),
      .k     (k_drv[g]),
      .q     (q[g]),
      .qbar  (qbar[g])
    );
  end

endmodule

// File: tb/tb_jk_bank_ctrl.sv
// Purpose: self-checking bench for jk_bank_ctrl with a response scoreboard.
// Latency: expects responses one cycle after the last q update.
// Backpressure: drives valid until ready, consumes every rsp_valid pulse.
module tb_jk_bank_ctrl;

  logic       clk;
  logic       CLR_N;
  logic       r0_valid, r1_valid;
  logic [1:0] r0_op, r1_op;
  logic [7:0] r0_j, r0_k, r1_j, r1_k;
  logic [3:0] r0_len, r1_len;
  logic       r0_ready, r1_ready;
  logic [7:0] q, qbar;
  logic       busy, rsp_valid, rsp_id, rsp_carry;
  logic [7:0] rsp_q;

  typedef struct {
    logic       id;
    logic [7:0] q;
    logic       carry;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  jk_bank_ctrl #(.WIDTH(8), .LENW(4)) dut (
    .clk       (clk),
    .CLR_N     (CLR_N),
    .r0_valid  (r0_valid),
    .r0_op     (r0_op),
    .r0_j      (r0_j),
    .r0_k      (r0_k),
    .r0_len    (r0_len),
    .r0_ready  (r0_ready),
    .r1_valid  (r1_valid),
    .r1_op     (r1_op),
    .r1_j      (r1_j),
    .r1_k      (r1_k),
    .r1_len    (r1_len),
    .r1_ready  (r1_ready),
    .q         (q),
    .qbar      (qbar),
    .busy      (busy),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_q     (rsp_q),
    .rsp_carry (rsp_carry)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic expect_rsp(input logic id, input logic [7:0] eq, input logic carry);
    exp_t e;
    e.id    = id;
    e.q     = eq;
    e.carry = carry;
    sb.push_back(e);
  endtask

  // Present one request and hold it until the accept edge.
  task automatic send(input logic id, input logic [1:0] op, input logic [7:0] j,
                      input logic [7:0] k, input logic [3:0] len);
    int n;
    if (id == 1'b0) begin
      r0_op = op; r0_j = j; r0_k = k; r0_len = len; r0_valid = 1'b1;
    end else begin
      r1_op = op; r1_j = j; r1_k = k; r1_len = len; r1_valid = 1'b1;
    end
    n = 0;
    @(negedge clk);
    while (!(id ? r1_ready : r0_ready) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("accept_in_time", (n < 40), 1);
    @(posedge clk);
    #1;
    if (id == 1'b0) r0_valid = 1'b0;
    else            r1_valid = 1'b0;
  endtask

  // Monitor: every response pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (rsp_valid) begin
      chk("rsp_expected", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_id", rsp_id, e.id);
        chk("rsp_q", rsp_q, e.q);
        chk("rsp_carry", rsp_carry, e.carry);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cnt_q [3];
    logic       exp0;
    cnt_q[0] = 8'h00; cnt_q[1] = 8'h01; cnt_q[2] = 8'h02;

    CLR_N = 1'b0;
    r0_valid = 1'b1; r1_valid = 1'b0;
    r0_op = 2'b10; r1_op = 2'b10;
    r0_j = '0; r0_k = '0; r1_j = '0; r1_k = '0; r0_len = '0; r1_len = '0;

    // Reset state, with a valid request that must not see ready.
    #12;
    chk("rst_q", q, 8'h00);
    chk("rst_qbar", qbar, 8'hFF);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_r0_ready", r0_ready, 0);
    chk("rst_r1_ready", r1_ready, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;
    r0_valid = 1'b0;
    CLR_N = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_q", q, 8'h00);
    chk("idle_qbar", qbar, 8'hFF);

    // JK semantics: set, toggle, reset, hold in one mask pair.
    expect_rsp(1'b0, 8'h0F, 1'b0);
    send(1'b0, 2'b00, 8'h0F, 8'h3C, 4'd0);
    chk("jk1_q", q, 8'h0F);
    expect_rsp(1'b0, 8'h03, 1'b0);
    send(1'b0, 2'b00, 8'h0F, 8'h3C, 4'd0);
    chk("jk2_q", q, 8'h03);
    chk("jk2_qbar", qbar, 8'hFC);

    // Immediate asynchronous reset.
    @(posedge clk); #1;
    CLR_N = 1'b0;
    #1;
    chk("async_rst_q", q, 8'h00);
    @(posedge clk); #1;
    CLR_N = 1'b1;

    // Arbitration after reset: r0 first, then r1.
    r1_op = 2'b11; r1_j = 8'hAA; r1_valid = 1'b1;
    r0_op = 2'b10; r0_valid = 1'b1;
    @(negedge clk);
    chk("arb_r0_first", r0_ready, 1);
    chk("arb_r1_wait", r1_ready, 0);
    expect_rsp(1'b0, 8'h00, 1'b0);
    @(posedge clk); #1;
    r0_valid = 1'b0;
    @(negedge clk);
    chk("arb_r1_second", r1_ready, 1);
    expect_rsp(1'b1, 8'hAA, 1'b0);
    @(posedge clk); #1;
    r1_valid = 1'b0;
    chk("load_q", q, 8'hAA);

    // Both held valid: grants alternate, starting with r0.
    r0_op = 2'b00; r0_j = 8'h00; r0_k = 8'h00; r0_valid = 1'b1;
    r1_op = 2'b10; r1_valid = 1'b1;
    exp0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("alt_r0_ready", r0_ready, exp0);
      chk("alt_r1_ready", r1_ready, !exp0);
      expect_rsp(!exp0, 8'hAA, 1'b0);
      @(posedge clk); #1;
      exp0 = !exp0;
    end
    r0_valid = 1'b0; r1_valid = 1'b0;

    // COUNT with wrap: FE -> FF,00,01,02.
    expect_rsp(1'b0, 8'hFE, 1'b0);
    send(1'b0, 2'b11, 8'hFE, 8'h00, 4'd0);
    expect_rsp(1'b1, 8'h02, 1'b1);
    send(1'b1, 2'b01, 8'h00, 8'h00, 4'd3);
    chk("cnt_first_q", q, 8'hFF);
    r0_op = 2'b10; r0_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("cnt_busy", busy, 1);
      chk("cnt_ready_low", r0_ready, 0);
      @(posedge clk); #1;
      chk("cnt_step_q", q, cnt_q[i]);
    end
    @(negedge clk);
    chk("cnt_done_busy", busy, 0);
    chk("cnt_rsp_now", rsp_valid, 1);
    chk("cnt_next_ready", r0_ready, 1);
    expect_rsp(1'b0, 8'h02, 1'b0);
    @(posedge clk); #1;
    r0_valid = 1'b0;

    // COUNT len=0 from 0x05.
    expect_rsp(1'b1, 8'h05, 1'b0);
    send(1'b1, 2'b11, 8'h05, 8'h00, 4'd0);
    expect_rsp(1'b0, 8'h06, 1'b0);
    send(1'b0, 2'b01, 8'h00, 8'h00, 4'd0);
    chk("cnt0_q", q, 8'h06);
    chk("cnt0_busy", busy, 0);

    // Reset mid-COUNT aborts with no response.
    expect_rsp(1'b0, 8'h10, 1'b0);
    send(1'b0, 2'b11, 8'h10, 8'h00, 4'd0);
    send(1'b1, 2'b01, 8'h00, 8'h00, 4'd8);
    chk("abort_first_q", q, 8'h11);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_pre_q", q, 8'h14);
    chk("abort_pre_busy", busy, 1);
    CLR_N = 1'b0;
    #1;
    chk("abort_q", q, 8'h00);
    chk("abort_qbar", qbar, 8'hFF);
    chk("abort_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    CLR_N = 1'b1;
    expect_rsp(1'b1, 8'h00, 1'b0);
    send(1'b1, 2'b10, 8'h00, 8'h00, 4'd0);

    repeat (4) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
